// File: rtl/retospect_pkg.sv
// Shared types and constants for the retospect configuration loader.
// Holds the loader state encoding, chain geometry and the CRC-8 step used by the optional check.
package retospect_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT,
        ST_CRC,
        ST_ARM,
        ST_DONE
    } state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    localparam int CLOCKBOX_BITS     = 48;
    localparam int CNB_BITS          = 19;
    localparam int CNB_CELLS         = 25;
    localparam int CHAIN_LEN_DEFAULT = CLOCKBOX_BITS + CNB_CELLS * CNB_BITS;

    // One bit-serial CRC-8 step, bits fed in the same order they leave on the chain.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/retospect_crc8_serial.sv
// Bit-serial CRC-8 accumulator over the configuration bits as they are shifted out.
// Only instantiated when RETOSPECT_CFG_CRC_EN is defined.
module retospect_crc8_serial
    import retospect_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [7:0] crc_o
);

    logic [7:0] crc_q;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            crc_q <= 8'h00;
        end else if (en_i) begin
            crc_q <= crc8_step(crc_q, bit_i);
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/retospect_cfg_loader.sv
// Byte-wide loader that serialises host bytes LSB-first onto the clockbox/cnb configuration chain.
// Define RETOSPECT_CFG_CRC_EN to require a trailing CRC-8 byte before the neuron-state reset pulse.
module retospect_cfg_loader
    import retospect_pkg::*;
#(
    parameter int CHAIN_LEN = CHAIN_LEN_DEFAULT,
    parameter int CNT_W     = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [7:0]       in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic             cfg_en_o,
    output logic             cfg_bit_o,
    output logic             nn_reset_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] bits_left_o
);

    state_t           state_q, state_d;
    logic [7:0]       sreg_q;
    logic [3:0]       nbits_q;
    logic [CNT_W-1:0] bits_left_q;
    logic             done_q;
    logic             in_ready_q;
    logic             cfg_en_q;
    logic             cfg_bit_q;
    logic             nn_reset_q;
    logic             busy_q;
    logic             start_ok;
    logic [3:0]       first_nbits;

    assign start_ok    = (state_q == ST_IDLE || state_q == ST_DONE) && start_i && !abort_i;
    assign first_nbits = (bits_left_q < CNT_W'(8)) ? bits_left_q[3:0] : 4'd8;

`ifdef RETOSPECT_CFG_CRC_EN
    logic [7:0] crc;
    logic       err_q;

    retospect_crc8_serial u_crc (
        .clk    (clk),
        .reset  (reset),
        .clear_i(start_ok),
        .en_i   (state_q == ST_SHIFT),
        .bit_i  (cfg_bit_q),
        .crc_o  (crc)
    );

    always_ff @(posedge clk) begin
        if (reset || start_ok) begin
            err_q <= 1'b0;
        end else if (state_q == ST_CRC && state_d == ST_DONE) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start_i) state_d = ST_FETCH;
            ST_FETCH:         if (in_valid_i) state_d = ST_SHIFT;
            ST_SHIFT: begin
                // The final partial byte ends on bits_left, not nbits, so that test comes first.
                if (bits_left_q == CNT_W'(1)) begin
`ifdef RETOSPECT_CFG_CRC_EN
                    state_d = ST_CRC;
`else
                    state_d = ST_ARM;
`endif
                end else if (nbits_q == 4'd1) begin
                    state_d = ST_FETCH;
                end
            end
`ifdef RETOSPECT_CFG_CRC_EN
            ST_CRC:           if (in_valid_i) state_d = (in_data_i == crc) ? ST_ARM : ST_DONE;
`endif
            ST_ARM:           state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
        if (abort_i) state_d = ST_IDLE;
    end

    // Outputs are registered from the next state so the chain sees clean, glitch-free strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sreg_q      <= 8'h00;
            nbits_q     <= 4'd0;
            bits_left_q <= '0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            cfg_en_q    <= 1'b0;
            cfg_bit_q   <= 1'b0;
            nn_reset_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d == ST_FETCH) || (state_d == ST_CRC);
            cfg_en_q   <= (state_d == ST_SHIFT);
            nn_reset_q <= (state_d == ST_ARM);
            busy_q     <= !(state_d == ST_IDLE || state_d == ST_DONE);
            cfg_bit_q  <= 1'b0;
            if (state_d == ST_SHIFT) begin
                cfg_bit_q <= (state_q == ST_FETCH) ? in_data_i[0] : sreg_q[1];
            end
            if (start_ok) begin
                bits_left_q <= CNT_W'(CHAIN_LEN);
                done_q      <= 1'b0;
            end
            if (state_q == ST_FETCH && state_d == ST_SHIFT) begin
                sreg_q  <= in_data_i;
                nbits_q <= first_nbits;
            end
            if (state_q == ST_SHIFT) begin
                sreg_q      <= {1'b0, sreg_q[7:1]};
                nbits_q     <= nbits_q - 4'd1;
                bits_left_q <= bits_left_q - CNT_W'(1);
            end
            if (state_q == ST_ARM && state_d == ST_DONE) begin
                done_q <= 1'b1;
            end
        end
    end

    assign in_ready_o  = in_ready_q;
    assign cfg_en_o    = cfg_en_q;
    assign cfg_bit_o   = cfg_bit_q;
    assign nn_reset_o  = nn_reset_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign bits_left_o = bits_left_q;

endmodule

// File: tb/tb_retospect_cfg_loader.sv
// Scoreboard bench for retospect_cfg_loader: three loaders (523, 12 and 8 chain bits) driven one at a time.
// Expected chain bits are queued when a byte is accepted and popped on every cfg_en cycle.
module tb_retospect_cfg_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       startS[3], abortS[3], inValidS[3];
    logic [7:0] inDataS[3];
    logic       inReady[3], cfgEn[3], cfgBit[3], nnReset[3], busy[3], doneS[3], errS[3];
    logic [9:0] bitsLeft[3];

    int errors = 0, checks = 0, cyc = 0;
    int enCount, nnCount, obsN, remBits, startCyc, doneCyc;
    int cur = 0;
    logic       monOn = 1'b0;
    logic [15:0] obsVec;
    logic [7:0] crcModel;
    logic       expBit;
    logic       expQ[$];

`ifdef RETOSPECT_CFG_CRC_EN
    localparam int CRC_EXTRA = 1;
`else
    localparam int CRC_EXTRA = 0;
`endif

    for (genvar g = 0; g < 3; g++) begin : gUnit
        localparam int L = (g == 0) ? 523 : (g == 1) ? 12 : 8;
        retospect_cfg_loader #(.CHAIN_LEN(L), .CNT_W(10)) dut (
            .clk        (clk),
            .reset      (reset),
            .start_i    (startS[g]),
            .abort_i    (abortS[g]),
            .in_data_i  (inDataS[g]),
            .in_valid_i (inValidS[g]),
            .in_ready_o (inReady[g]),
            .cfg_en_o   (cfgEn[g]),
            .cfg_bit_o  (cfgBit[g]),
            .nn_reset_o (nnReset[g]),
            .busy_o     (busy[g]),
            .done_o     (doneS[g]),
            .err_o      (errS[g]),
            .bits_left_o(bitsLeft[g])
        );
    end

    function automatic int lenOf(input int u);
        case (u)
            0:       return 523;
            1:       return 12;
            default: return 8;
        endcase
    endfunction

    function automatic logic [7:0] crcStep(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Chain-side monitor: every shifted bit must be the next queued bit, never alongside in_ready.
    always @(negedge clk) begin
        if (monOn) begin
            if (nnReset[cur]) nnCount++;
            if (cfgEn[cur]) begin
                enCount++;
                if (expQ.size() == 0) begin
                    checkOutput("extraShift", 1, 0);
                end else begin
                    expBit = expQ.pop_front();
                    checkOutput("cfgBit", cfgBit[cur], expBit);
                end
                if (obsN < 16) obsVec[obsN] = cfgBit[cur];
                obsN++;
                checkOutput("enWithReady", inReady[cur], 0);
            end
        end
    end

    task automatic checkResetOutputs(input int u);
        checkOutput("rstReady", inReady[u], 0);
        checkOutput("rstCfgEn", cfgEn[u], 0);
        checkOutput("rstCfgBit", cfgBit[u], 0);
        checkOutput("rstNnReset", nnReset[u], 0);
        checkOutput("rstBusy", busy[u], 0);
        checkOutput("rstDone", doneS[u], 0);
        checkOutput("rstErr", errS[u], 0);
        checkOutput("rstBitsLeft", bitsLeft[u], 0);
    endtask

    task automatic startLoad(input int u);
        cur = u;
        expQ.delete();
        enCount = 0; nnCount = 0; obsN = 0; obsVec = '0; crcModel = 8'h00;
        remBits = lenOf(u);
        startS[u] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        startS[u] = 1'b0;
        startCyc = cyc;
        checkOutput("busyAfterStart", busy[u], 1);
        checkOutput("bitsLeftStart", bitsLeft[u], lenOf(u));
        checkOutput("doneCleared", doneS[u], 0);
        checkOutput("readyInFetch", inReady[u], 1);
    endtask

    // Offers one byte (valid stays high through SHIFT) and queues the bits the chain should see.
    task automatic applyStimulus(input int u, input logic [7:0] b, input int gap);
        int t, n;
        if (gap > 0) begin
            inValidS[u] = 1'b0;
            repeat (gap) @(negedge clk);
        end
        inDataS[u]  = b;
        inValidS[u] = 1'b1;
        t = 0;
        while (inReady[u] !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (inReady[u] !== 1'b1) begin
            checkOutput("readyTimeout", 0, 1);
            return;
        end
        checkOutput("enInFetch", cfgEn[u], 0);
        n = (remBits < 8) ? remBits : 8;
        for (int i = 0; i < n; i++) begin
            expQ.push_back(b[i]);
            crcModel = crcStep(crcModel, b[i]);
        end
        remBits -= n;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sendCrc(input int u, input logic [7:0] c);
        int t;
        inDataS[u]  = c;
        inValidS[u] = 1'b1;
        t = 0;
        while (inReady[u] !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (inReady[u] !== 1'b1) checkOutput("crcReadyTimeout", 0, 1);
        else checkOutput("enInCrc", cfgEn[u], 0);
        @(posedge clk);
        @(negedge clk);
        inValidS[u] = 1'b0;
    endtask

    task automatic waitDone(input int u);
        int t;
        inValidS[u] = 1'b0;
        t = 0;
        while (doneS[u] !== 1'b1 && errS[u] !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        doneCyc = cyc;
        if (doneS[u] !== 1'b1 && errS[u] !== 1'b1) checkOutput("doneTimeout", 0, 1);
    endtask

    task automatic runFullLoad(input int u, input int gapMax, input bit chkLat);
        int len;
        len = lenOf(u);
        startLoad(u);
        for (int i = 0; i < (len + 7) / 8; i++) begin
            applyStimulus(u, 8'($urandom), (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0);
        end
`ifdef RETOSPECT_CFG_CRC_EN
        sendCrc(u, crcModel);
`endif
        waitDone(u);
        if (chkLat) checkOutput("doneLatency", doneCyc - startCyc + 1, len + (len + 7) / 8 + 2 + CRC_EXTRA);
        repeat (2) @(negedge clk);
        checkOutput("enCount", enCount, len);
        checkOutput("queueDrained", expQ.size(), 0);
        checkOutput("nnPulses", nnCount, 1);
        checkOutput("doneHigh", doneS[u], 1);
        checkOutput("errLow", errS[u], 0);
        checkOutput("busyLow", busy[u], 0);
        checkOutput("bitsLeftEnd", bitsLeft[u], 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t;
        reset = 1'b1;
        for (int u = 0; u < 3; u++) begin
            startS[u] = 1'b0; abortS[u] = 1'b0; inValidS[u] = 1'b0; inDataS[u] = 8'h00;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs(0);
        reset = 1'b0;
        monOn = 1'b1;
        @(negedge clk);

        $display("[TB] full 523-bit load, no stalls");
        runFullLoad(0, 0, 1'b1);

        $display("[TB] 12-bit load of A5 FF with start pulsed mid-shift");
        startLoad(1);
        applyStimulus(1, 8'hA5, 0);
        startS[1] = 1'b1;
        @(negedge clk);
        startS[1] = 1'b0;
        applyStimulus(1, 8'hFF, 0);
`ifdef RETOSPECT_CFG_CRC_EN
        sendCrc(1, crcModel);
`endif
        waitDone(1);
        repeat (2) @(negedge clk);
        checkOutput("shortBitCount", obsN, 12);
        checkOutput("shortBits", obsVec[11:0], 12'hFA5);
        checkOutput("shortNn", nnCount, 1);
        checkOutput("shortDone", doneS[1], 1);
        checkOutput("shortQueue", expQ.size(), 0);

        $display("[TB] 523-bit load with random valid gaps");
        runFullLoad(0, 3, 1'b0);

        $display("[TB] abort after 100 bits");
        startLoad(0);
        for (int i = 0; i < 13; i++) applyStimulus(0, 8'($urandom), 0);
        t = 0;
        while (enCount < 100 && t < 50) begin
            @(negedge clk);
            t++;
        end
        abortS[0]   = 1'b1;
        inValidS[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        abortS[0] = 1'b0;
        checkOutput("abortCfgEn", cfgEn[0], 0);
        checkOutput("abortBusy", busy[0], 0);
        checkOutput("abortReady", inReady[0], 0);
        checkOutput("abortDone", doneS[0], 0);
        expQ.delete();
        repeat (5) @(negedge clk);
        checkOutput("abortNoNn", nnCount, 0);
        checkOutput("abortIdleEn", cfgEn[0], 0);
        runFullLoad(0, 0, 1'b1);

        $display("[TB] reset during SHIFT");
        startLoad(1);
        applyStimulus(1, 8'hA5, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        inValidS[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkResetOutputs(1);
        reset = 1'b0;
        expQ.delete();
        @(negedge clk);

        $display("[TB] 8-bit load of 01");
        startLoad(2);
        applyStimulus(2, 8'h01, 0);
`ifdef RETOSPECT_CFG_CRC_EN
        sendCrc(2, 8'h89);
`endif
        waitDone(2);
        repeat (2) @(negedge clk);
        checkOutput("crcGoodNn", nnCount, 1);
        checkOutput("crcGoodDone", doneS[2], 1);
        checkOutput("crcGoodErr", errS[2], 0);
        checkOutput("crcGoodEn", enCount, 8);
`ifdef RETOSPECT_CFG_CRC_EN
        startLoad(2);
        applyStimulus(2, 8'h01, 0);
        sendCrc(2, 8'h88);
        waitDone(2);
        repeat (3) @(negedge clk);
        checkOutput("crcBadErr", errS[2], 1);
        checkOutput("crcBadDone", doneS[2], 0);
        checkOutput("crcBadNn", nnCount, 0);
        checkOutput("crcBadBusy", busy[2], 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
